// File: rtl/batch_pkg.sv
// Shared types and constants for the batch consumer.
// State encoding, default batch limit and count width.
package batch_pkg;

   localparam int MAX_BATCH_DEF = 16;
   localparam int BATCH_CNT_W   = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DRAIN,
      ST_DONE
   } bc_state_t;

endpackage

// File: rtl/out_reg_stage.sv
// Output register with valid/ready hold behaviour.
// Loads one word per load pulse and holds it until accepted.
module out_reg_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   // Capture returned buffer word; drop valid once the beat is taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_last  <= load_last;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: rtl/batch_consumer.sv
// Requests batch counts, reads that many buffer words and
// streams them out, tracking beat totals and overflow errors.
module batch_consumer
   import batch_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MAX_BATCH = MAX_BATCH_DEF,
   parameter int BATCH_LAT = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   req_next,
   input  logic [BATCH_CNT_W-1:0] batch_cnt,
   input  logic                   batch_last,
   output logic                   buf_rd_en,
   input  logic [DATA_W-1:0]      buf_rd_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [31:0]            total_count
);

   localparam int LAT_W = $clog2(BATCH_LAT + 1);

   bc_state_t state, state_nx;

   logic [LAT_W-1:0]       wait_cnt;
   logic [BATCH_CNT_W-1:0] remaining;
   logic [BATCH_CNT_W-1:0] cnt_clamp;
   logic                   last_r;
   logic                   rd_pend;
   logic                   over;
   logic                   sample;
   logic                   accept;
   logic                   load_last;

   assign over      = batch_cnt > BATCH_CNT_W'(MAX_BATCH);
   assign cnt_clamp = over ? BATCH_CNT_W'(MAX_BATCH) : batch_cnt;
   assign accept    = out_valid & out_ready;
   assign load_last = last_r & (remaining == '0);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   // Next-state, request pulse, read strobe and sample enable.
   always_comb begin
      state_nx  = state;
      req_next  = 1'b0;
      buf_rd_en = 1'b0;
      sample    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) state_nx = ST_REQ;
         end
         ST_REQ: begin
            req_next = 1'b1;
            state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt == LAT_W'(BATCH_LAT)) begin
               sample = 1'b1;
               if (cnt_clamp != '0)
                  state_nx = ST_DRAIN;
               else if (batch_last)
                  state_nx = ST_DONE;
               else
                  state_nx = ST_REQ;
            end
         end
         ST_DRAIN: begin
            buf_rd_en = (remaining != '0) && !rd_pend &&
                        (!out_valid || out_ready);
            if (remaining == '0 && !rd_pend && accept)
               state_nx = last_r ? ST_DONE : ST_REQ;
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Latency counter, batch capture and remaining-word tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt  <= '0;
         remaining <= '0;
         last_r    <= 1'b0;
         rd_pend   <= 1'b0;
      end else begin
         rd_pend <= buf_rd_en;
         if (state == ST_REQ)
            wait_cnt <= LAT_W'(1);
         else if (state == ST_WAIT)
            wait_cnt <= wait_cnt + 1'b1;
         if (sample) begin
            remaining <= cnt_clamp;
            last_r    <= batch_last;
         end else if (buf_rd_en) begin
            remaining <= remaining - 1'b1;
         end
      end
   end

   // Job status: sticky overflow flag and accepted-beat total.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err         <= 1'b0;
         total_count <= '0;
      end else if (state == ST_IDLE && start) begin
         err         <= 1'b0;
         total_count <= '0;
      end else begin
         if (sample && over) err <= 1'b1;
         if (accept) total_count <= total_count + 32'd1;
      end
   end

   out_reg_stage #(
      .DATA_W (DATA_W)
   ) u_out (
      .clk       (clk),
      .rst       (rst),
      .load      (rd_pend),
      .load_data (buf_rd_data),
      .load_last (load_last),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last)
   );

endmodule

// File: tb/tb_batch_consumer.sv
// Bench for batch_consumer: batch issuer, buffer and sink models
// plus a job-level reference computed from the batch list.
module tb_batch_consumer;
   import batch_pkg::*;

   localparam int DW  = 32;
   localparam int MB  = 16;
   localparam int LAT = 2;

   logic          clk, rst, start;
   logic          req_next;
   logic [4:0]    batch_cnt;
   logic          batch_last;
   logic          buf_rd_en;
   logic [DW-1:0] buf_rd_data;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_data;
   logic          out_last, busy, done, err;
   logic [31:0]   total_count;

   batch_consumer #(
      .DATA_W    (DW),
      .MAX_BATCH (MB),
      .BATCH_LAT (LAT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .req_next    (req_next),
      .batch_cnt   (batch_cnt),
      .batch_last  (batch_last),
      .buf_rd_en   (buf_rd_en),
      .buf_rd_data (buf_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .total_count (total_count)
   );

   typedef struct {
      int cnt;
      bit last;
   } batch_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   batch_t jq[$];
   batch_t bq[$];
   batch_t cur;
   int present_cyc = -10;

   logic [DW-1:0] served_q[$];
   logic [DW-1:0] beat_q[$];
   bit            last_q[$];
   int            acc_cyc[$];
   int done_cnt, req_cnt, rd_cnt, done_cyc;
   bit rd_prev = 0;

   int rmode = 0;
   int stall_beat = -1;
   bit stall_armed = 0;
   int stall_left = 0;
   bit stall_active = 0;
   logic [DW-1:0] held;

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive issuer, buffer and sink at negedge; then observe.
   always @(negedge clk) begin
      if (cyc == present_cyc) begin
         batch_cnt  = 5'(cur.cnt);
         batch_last = cur.last;
      end else begin
         batch_cnt  = 5'($urandom);
         batch_last = 1'($urandom);
      end
      if (rd_prev) begin
         buf_rd_data = $urandom;
         served_q.push_back(buf_rd_data);
      end else begin
         buf_rd_data = $urandom;
      end
      if (stall_armed && out_valid && beat_q.size() == stall_beat - 1) begin
         stall_armed = 0;
         stall_left  = 4;
         held        = out_data;
      end
      if (stall_left > 0) begin
         out_ready    = 0;
         stall_left--;
         stall_active = 1;
      end else begin
         stall_active = 0;
         out_ready    = (rmode == 1) ? 1'($urandom) : 1'b1;
      end
      #1;
      rd_prev = buf_rd_en;
      if (buf_rd_en) rd_cnt++;
      if (req_next) begin
         req_cnt++;
         if (bq.size() > 0) cur = bq.pop_front();
         else cur = '{cnt: 0, last: 1};
         present_cyc = cyc + LAT;
      end
      if (out_valid && out_ready) begin
         beat_q.push_back(out_data);
         last_q.push_back(out_last);
         acc_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (stall_active) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, held);
         chk("stall_rd", buf_rd_en, 0);
      end
   end

   task automatic add(input int c, input bit l);
      jq.push_back('{cnt: c, last: l});
   endtask

   task automatic clear_obs();
      served_q.delete();
      beat_q.delete();
      last_q.delete();
      acc_cyc.delete();
      done_cnt = 0;
      req_cnt  = 0;
      rd_cnt   = 0;
      done_cyc = -1;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      #2;
      chk("start_busy", busy, 1);
      chk("start_err_clr", err, 0);
      chk("start_total_clr", total_count, 0);
   endtask

   task automatic run_job(input string tag, input int budget);
      int exp_beats, nlast, bad, n, m;
      bit exp_err;
      exp_beats = 0;
      exp_err   = 0;
      foreach (jq[i]) begin
         exp_beats += (jq[i].cnt > MB) ? MB : jq[i].cnt;
         if (jq[i].cnt > MB) exp_err = 1;
      end
      bq = jq;
      clear_obs();
      pulse_start();
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_finished"}, done_cnt > 0, 1);
      @(negedge clk);
      #2;
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_reqs"}, req_cnt, jq.size());
      chk({tag, "_beats"}, beat_q.size(), exp_beats);
      chk({tag, "_reads"}, rd_cnt, exp_beats);
      chk({tag, "_total"}, total_count, exp_beats);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_idle"}, busy, 0);
      bad = 0;
      m = (beat_q.size() < served_q.size()) ? beat_q.size() : served_q.size();
      for (int i = 0; i < m; i++)
         if (beat_q[i] !== served_q[i]) bad++;
      chk({tag, "_data_order"}, bad, 0);
      nlast = 0;
      foreach (last_q[i]) nlast += last_q[i];
      chk({tag, "_last_count"}, nlast, (exp_beats > 0) ? 1 : 0);
      if (exp_beats > 0)
         chk({tag, "_last_final"}, last_q[last_q.size()-1], 1);
   endtask

   initial begin
      int bad, n, nb;
      rst = 1;
      start = 0;
      out_ready = 1;
      batch_cnt = 0;
      batch_last = 0;
      buf_rd_data = 0;
      clear_obs();
      #2 rst = 0;
      #1;
      chk("rst_req_next", req_next, 0);
      chk("rst_rd_en", buf_rd_en, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_total", total_count, 0);
      chk("rst_data", out_data, 0);
      repeat (2) @(negedge clk);
      rst = 1;

      // 40 words in 16/16/8, random backpressure
      rmode = 1;
      jq.delete();
      add(16, 0); add(16, 0); add(8, 1);
      run_job("job40", 3000);

      // single full batch, sink always ready
      rmode = 0;
      jq.delete();
      add(16, 1);
      run_job("b16", 1000);
      bad = 0;
      for (int i = 1; i < acc_cyc.size(); i++)
         if (acc_cyc[i] - acc_cyc[i-1] != 2) bad++;
      chk("b16_spacing", bad, 0);
      if (acc_cyc.size() > 0)
         chk("b16_done_lat", done_cyc, acc_cyc[acc_cyc.size()-1] + 1);

      // empty final batch
      jq.delete();
      add(0, 1);
      run_job("b0", 200);

      // stall on beat 3
      stall_beat  = 3;
      stall_armed = 1;
      jq.delete();
      add(5, 1);
      run_job("stall", 500);
      chk("stall_used", stall_armed, 0);

      // oversize batch clamps and flags
      jq.delete();
      add(20, 1);
      run_job("over", 1000);

      // err clears at next start; random jobs
      rmode = 1;
      for (int j = 0; j < 3; j++) begin
         jq.delete();
         nb = $urandom_range(1, 3);
         for (int i = 0; i < nb; i++)
            add($urandom_range(0, 20), i == nb - 1);
         run_job($sformatf("rnd%0d", j), 4000);
      end

      // reset in the middle of a 10-word drain
      rmode = 0;
      jq.delete();
      add(10, 1);
      bq = jq;
      clear_obs();
      pulse_start();
      n = 0;
      while (beat_q.size() < 3 && n < 500) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk("mid_reached_beat3", beat_q.size(), 3);
      rst = 0;
      #1;
      chk("mid_rst_req", req_next, 0);
      chk("mid_rst_rd", buf_rd_en, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_last", out_last, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_total", total_count, 0);
      chk("mid_rst_data", out_data, 0);
      repeat (3) @(negedge clk);
      #2;
      chk("mid_rst_no_done", done_cnt, 0);
      rst = 1;
      present_cyc = -10;
      repeat (2) @(negedge clk);
      jq.delete();
      add(4, 1);
      run_job("after_rst", 500);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
